// File: rtl/uart_tx_frame_if.sv
// Request/serial-line bundle for the UART frame transmitter, including the
// side channel to the parity calculator.
interface uart_tx_frame_if;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       PAR_BIT;
    logic [7:0] DATA_LAT;
    logic       PAR_TYP_LAT;
    logic       par_calc_en;
    logic       TX_OUT;
    logic       BUSY;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, PAR_BIT,
        input  DATA_LAT, PAR_TYP_LAT, par_calc_en, TX_OUT, BUSY
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, PAR_BIT,
        output DATA_LAT, PAR_TYP_LAT, par_calc_en, TX_OUT, BUSY
    );
endinterface

// File: rtl/uart_tx_frame.sv
// UART frame serializer: start bit, 8 data bits LSB-first, optional parity, stop.
// One clock per bit; all outputs registered so TX_OUT reflects the current state.
module uart_tx_frame (
    input  logic           clk,
    input  logic           rst,
    uart_tx_frame_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t     state;
    logic [2:0] cnt;
    logic       par_en_lat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= 3'd0;
            par_en_lat      <= 1'b0;
            bus.DATA_LAT    <= 8'h00;
            bus.PAR_TYP_LAT <= 1'b0;
            bus.par_calc_en <= 1'b0;
            bus.TX_OUT      <= 1'b1;
            bus.BUSY        <= 1'b0;
        end else begin
            bus.par_calc_en <= 1'b0;
            case (state)
                // The stop cycle doubles as an acceptance window for back-to-back frames.
                IDLE, STOP: begin
                    if (bus.DATA_VALID) begin
                        state           <= START;
                        bus.DATA_LAT    <= bus.P_DATA;
                        bus.PAR_TYP_LAT <= bus.PAR_TYP;
                        par_en_lat      <= bus.PAR_EN;
                        bus.par_calc_en <= bus.PAR_EN;
                        bus.TX_OUT      <= 1'b0;
                        bus.BUSY        <= 1'b1;
                    end else begin
                        state      <= IDLE;
                        bus.TX_OUT <= 1'b1;
                        bus.BUSY   <= 1'b0;
                    end
                end
                START: begin
                    state      <= DATA;
                    cnt        <= 3'd0;
                    bus.TX_OUT <= bus.DATA_LAT[0];
                end
                DATA: begin
                    if (cnt == 3'd7) begin
                        cnt <= 3'd0;
                        if (par_en_lat) begin
                            // parity_calc was strobed 8+ cycles ago, so PAR_BIT is settled.
                            state      <= PARITY;
                            bus.TX_OUT <= bus.PAR_BIT;
                        end else begin
                            state      <= STOP;
                            bus.TX_OUT <= 1'b1;
                            bus.BUSY   <= 1'b0;
                        end
                    end else begin
                        cnt        <= cnt + 3'd1;
                        bus.TX_OUT <= bus.DATA_LAT[cnt + 3'd1];
                    end
                end
                PARITY: begin
                    state      <= STOP;
                    bus.TX_OUT <= 1'b1;
                    bus.BUSY   <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    bus.TX_OUT <= 1'b1;
                    bus.BUSY   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: table of frames plus back-to-back, busy-ignore and
// mid-frame reset sequences, checked per cycle against a scoreboard queue.
module tb_uart_tx_frame;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_frame_if u_if ();
    uart_tx_frame u_dut (.clk(clk), .rst(rst), .bus(u_if));

    typedef struct {
        int         cyc;
        logic       tx;
        logic       busy;
        logic       pce;
        logic [7:0] lat;
        string      tag;
    } exp_t;

    typedef struct {
        logic [7:0]  data;
        logic        pe;
        logic        pt;
        logic [10:0] exp_tx;   // bit i = TX_OUT in frame cycle i
        int          len;
    } vec_t;

    exp_t sb[$];
    exp_t cur;
    vec_t vecs[8];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic par_bit_r;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for parity_calc: registers the parity on its strobe.
    always @(posedge clk) begin
        if (rst) par_bit_r <= 1'b0;
        else if (u_if.par_calc_en) par_bit_r <= (^u_if.DATA_LAT) ^ u_if.PAR_TYP_LAT;
    end
    assign u_if.PAR_BIT = par_bit_r;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            check($sformatf("%s_tx@%0d", cur.tag, cur.cyc), {7'd0, u_if.TX_OUT}, {7'd0, cur.tx});
            check($sformatf("%s_busy@%0d", cur.tag, cur.cyc), {7'd0, u_if.BUSY}, {7'd0, cur.busy});
            check($sformatf("%s_pce@%0d", cur.tag, cur.cyc), {7'd0, u_if.par_calc_en}, {7'd0, cur.pce});
            check($sformatf("%s_lat@%0d", cur.tag, cur.cyc), u_if.DATA_LAT, cur.lat);
        end
    end

    function automatic logic [10:0] model_tx(input logic [7:0] d, input logic pe, input logic pt);
        logic [10:0] t;
        t = '1;
        t[0] = 1'b0;
        for (int i = 0; i < 8; i++) t[i+1] = d[i];
        if (pe) t[9] = (^d) ^ pt;
        return t;
    endfunction

    task automatic push_frame(input int base, input logic [7:0] data, input logic pe,
                              input logic [10:0] tx, input int len, input int n, input string tag);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.cyc  = base + i;
            e.tx   = tx[i];
            e.busy = (i < len - 1);
            e.pce  = (i == 0) && pe;
            e.lat  = data;
            e.tag  = tag;
            sb.push_back(e);
        end
    endtask

    task automatic push_idle(input int at, input logic [7:0] lat, input string tag);
        exp_t e;
        e.cyc = at; e.tx = 1'b1; e.busy = 1'b0; e.pce = 1'b0; e.lat = lat; e.tag = tag;
        sb.push_back(e);
    endtask

    // Called #1 after an edge; request is accepted on the next edge.
    task automatic send(input vec_t v, input string tag);
        int base;
        u_if.P_DATA = v.data;
        u_if.PAR_EN = v.pe;
        u_if.PAR_TYP = v.pt;
        u_if.DATA_VALID = 1'b1;
        base = cyc + 1;
        push_frame(base, v.data, v.pe, v.exp_tx, v.len, v.len, tag);
        push_idle(base + v.len, v.data, {tag, "_idle"});
        @(posedge clk); #1;
        u_if.DATA_VALID = 1'b0;
        u_if.P_DATA = ~v.data;
        u_if.PAR_EN = ~v.pe;
        u_if.PAR_TYP = ~v.pt;
        repeat (v.len + 1) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        logic [10:0] m1;
        logic [10:0] m2;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 11'b10101001010, 11};
        vecs[1] = '{8'h80, 1'b1, 1'b1, 11'b10100000000, 11};
        vecs[2] = '{8'hC0, 1'b0, 1'b0, 11'b01110000000, 10};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 11'b10000000000, 11};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 11'b10000000010, 11};
        vecs[5] = '{8'hFF, 1'b0, 1'b1, 11'b01111111110, 10};
        vecs[6] = '{8'h3C, 1'b1, 1'b0, 11'b10001111000, 11};
        vecs[7] = '{8'h03, 1'b1, 1'b1, 11'b11000000110, 11};

        u_if.P_DATA = 8'h00;
        u_if.DATA_VALID = 1'b0;
        u_if.PAR_EN = 1'b0;
        u_if.PAR_TYP = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", {7'd0, u_if.TX_OUT}, 8'd1);
        check("rst_busy", {7'd0, u_if.BUSY}, 8'd0);
        check("rst_pce", {7'd0, u_if.par_calc_en}, 8'd0);
        check("rst_lat", u_if.DATA_LAT, 8'h00);
        check("rst_ptyp", {7'd0, u_if.PAR_TYP_LAT}, 8'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) send(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back: DATA_VALID held through the first stop cycle.
        u_if.P_DATA = 8'h55; u_if.PAR_EN = 1'b0; u_if.PAR_TYP = 1'b0; u_if.DATA_VALID = 1'b1;
        b = cyc + 1;
        m1 = model_tx(8'h55, 1'b0, 1'b0);
        m2 = model_tx(8'h0F, 1'b0, 1'b0);
        push_frame(b, 8'h55, 1'b0, m1, 10, 10, "b2b_a");
        push_frame(b + 10, 8'h0F, 1'b0, m2, 10, 10, "b2b_b");
        push_idle(b + 20, 8'h0F, "b2b_idle");
        @(posedge clk); #1;
        u_if.P_DATA = 8'h0F;
        repeat (10) @(posedge clk);
        #1;
        u_if.DATA_VALID = 1'b0;
        repeat (11) @(posedge clk);
        #1;

        // Request pulsed mid-frame must be dropped.
        u_if.P_DATA = 8'h3C; u_if.PAR_EN = 1'b1; u_if.PAR_TYP = 1'b0; u_if.DATA_VALID = 1'b1;
        b = cyc + 1;
        push_frame(b, 8'h3C, 1'b1, model_tx(8'h3C, 1'b1, 1'b0), 11, 11, "ign");
        push_idle(b + 11, 8'h3C, "ign_idle");
        push_idle(b + 12, 8'h3C, "ign_idle2");
        @(posedge clk); #1;
        u_if.DATA_VALID = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        u_if.DATA_VALID = 1'b1; u_if.P_DATA = 8'hFF; u_if.PAR_EN = 1'b0;
        @(posedge clk); #1;
        u_if.DATA_VALID = 1'b0;
        repeat (9) @(posedge clk);
        #1;

        // Reset during data bit 3, with a request presented in the reset cycle.
        u_if.P_DATA = 8'hA5; u_if.PAR_EN = 1'b0; u_if.PAR_TYP = 1'b0; u_if.DATA_VALID = 1'b1;
        b = cyc + 1;
        push_frame(b, 8'hA5, 1'b0, model_tx(8'hA5, 1'b0, 1'b0), 10, 5, "rstmid");
        push_idle(b + 5, 8'h00, "rstmid_after");
        push_idle(b + 6, 8'h00, "rstmid_after2");
        @(posedge clk); #1;
        u_if.DATA_VALID = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1; u_if.DATA_VALID = 1'b1; u_if.P_DATA = 8'hFF;
        @(posedge clk); #1;
        rst = 1'b0; u_if.DATA_VALID = 1'b0;
        @(posedge clk); #1;
        send(vecs[0], "post_rst");

        for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk);
        check("sb_drain", 8'(sb.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
